// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : periph_bus_arbiter
//  Purpose  : Two-master round-robin arbiter for the single-port peripheral
//             bus, with per-master lock, starvation limit and an optional
//             IRQ preemption selected by macro PBA_IRQ_PREEMPT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module periph_bus_arbiter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        rd0,
    input  logic        rd1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    input  logic        irq,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] c_hold_max  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic [HOLD_W-1:0]   r_hold;
    logic                w_xfer0;
    logic                w_xfer1;
    logic                w_irq_take;

`ifdef PBA_IRQ_PREEMPT_EN
    assign w_irq_take = irq & req0;
`else
    logic w_unused_irq;
    assign w_unused_irq = irq;
    assign w_irq_take   = 1'b0;
`endif

    assign gnt0    = (r_state == ST_GNT0);
    assign gnt1    = (r_state == ST_GNT1);
    assign w_xfer0 = gnt0 & req0;
    assign w_xfer1 = gnt1 & req1;

    // A locked owner yields only once its current transfer is the MAX_HOLD-th
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1)
                    w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                else if (req0)
                    w_state_nxt = ST_GNT0;
                else if (req1)
                    w_state_nxt = ST_GNT1;
            end
            ST_GNT0: begin
                if (!req0)
                    w_state_nxt = req1 ? ST_GNT1 : ST_IDLE;
                else if (req1 && (!lock0 || (r_hold >= c_hold_last)))
                    w_state_nxt = ST_GNT1;
            end
            ST_GNT1: begin
                if (!req1)
                    w_state_nxt = req0 ? ST_GNT0 : ST_IDLE;
                else if (req0 && (!lock1 || (r_hold >= c_hold_last)))
                    w_state_nxt = ST_GNT0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_irq_take)
            w_state_nxt = ST_GNT0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_hold <= '0;
            else if ((w_xfer0 || w_xfer1) && (r_hold != c_hold_max))
                r_hold <= r_hold + 1'b1;
            if ((r_state == ST_GNT0) && (w_state_nxt != ST_GNT0))
                r_last <= 1'b0;
            else if ((r_state == ST_GNT1) && (w_state_nxt != ST_GNT1))
                r_last <= 1'b1;
        end
    end

    // Write beats read when a master raises both strobes
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (w_xfer0) begin
            rd    = rd0 & ~wr0;
            wr    = wr0;
            addr  = addr0;
            wdata = wdata0;
        end else if (w_xfer1) begin
            rd    = rd1 & ~wr1;
            wr    = wr1;
            addr  = addr1;
            wdata = wdata1;
        end
    end

    assign rdata0 = gnt0 ? rdata : '0;
    assign rdata1 = gnt1 ? rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_periph_bus_arbiter
//  Purpose  : Randomized scoreboard bench for periph_bus_arbiter with a small
//             peripheral register model on the slave side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_periph_bus_arbiter;

    localparam int HOLD_W   = 4;
    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
    logic        rd0 = 0, rd1 = 0, wr0 = 0, wr1 = 0, irq = 0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rd, wr;
    logic [31:0] rdata0, rdata1, addr, wdata, rdata;
    logic [31:0] sw = '0;

    periph_bus_arbiter #(.HOLD_W(HOLD_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .irq(irq), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Peripheral: six word registers at 0x40000000..0x14, 0x10 = switches (read-only)
    logic [31:0] pregs [0:5];
    logic [31:0] mregs [0:5];

    always_comb begin
        rdata = '0;
        if (addr[31:5] == 27'h2000000) begin
            if (addr[4:2] == 3'd4)      rdata = sw;
            else if (addr[4:2] <= 3'd5) rdata = pregs[addr[4:2]];
        end
    end

    always @(posedge clk)
        if (wr && addr[31:5] == 27'h2000000 && addr[4:2] <= 3'd5 && addr[4:2] != 3'd4)
            pregs[addr[4:2]] <= wdata;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  strb;   // {wr, rd}
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference: who owns the bus, who was served last, transfers in this tenure
    int owner = -1;
    int last  = 1;
    int held  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != 27'h2000000) return '0;
        if (a[4:2] == 3'd4) return sw;
        if (a[4:2] <= 3'd5) return mregs[a[4:2]];
        return '0;
    endfunction

    // Push this cycle's expected outputs, then advance the reference one edge
    task automatic step();
        exp_t        e;
        bit          rq[2], lk[2], rdm[2], wrm[2];
        logic [31:0] ad[2], wd[2], rv;
        int          nxt, o;
        rq[0] = req0;  rq[1] = req1;  lk[0] = lock0; lk[1] = lock1;
        rdm[0] = rd0;  rdm[1] = rd1;  wrm[0] = wr0;  wrm[1] = wr1;
        ad[0] = addr0; ad[1] = addr1; wd[0] = wdata0; wd[1] = wdata1;
        e.gnt = 2'b00; e.strb = 2'b00; e.addr = '0; e.wdata = '0;
        e.rdata0 = '0; e.rdata1 = '0;
        if (reset && owner >= 0) begin
            e.gnt[owner] = 1'b1;
            if (rq[owner]) begin
                e.strb  = {wrm[owner], rdm[owner] & ~wrm[owner]};
                e.addr  = ad[owner];
                e.wdata = wd[owner];
            end
            rv = model_read(e.addr);
            if (owner == 0) e.rdata0 = rv;
            else            e.rdata1 = rv;
        end
        exp_q.push_back(e);
        if (e.strb[1] && e.addr[31:5] == 27'h2000000 && e.addr[4:2] <= 3'd5 && e.addr[4:2] != 3'd4)
            mregs[e.addr[4:2]] = e.wdata;

        if (!reset) begin
            owner = -1; last = 1; held = 0;
        end else begin
            if (owner < 0) begin
                if (rq[0] && rq[1]) nxt = 1 - last;
                else if (rq[0])     nxt = 0;
                else if (rq[1])     nxt = 1;
                else                nxt = -1;
            end else begin
                o = 1 - owner;
                if (!rq[owner])      nxt = rq[o] ? o : -1;
                else if (!rq[o])     nxt = owner;
                else if (!lk[owner]) nxt = o;
                else                 nxt = (held + 1 >= MAX_HOLD) ? o : owner;
            end
`ifdef PBA_IRQ_PREEMPT_EN
            if (irq && rq[0]) nxt = 0;
`endif
            if (nxt != owner) begin
                if (owner >= 0) last = owner;
                held = 0;
            end else if (owner >= 0) begin
                held++;
            end
            owner = nxt;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'h40000000 + 32'(4 * $urandom_range(0, 5));
    endfunction

    task automatic rand_inputs(input int req_pct, input int lock_pct);
        req0 = ($urandom_range(0, 99) < req_pct);
        req1 = ($urandom_range(0, 99) < req_pct);
        lock0 = ($urandom_range(0, 99) < lock_pct);
        lock1 = ($urandom_range(0, 99) < lock_pct);
        rd0 = $urandom_range(0, 1); wr0 = ($urandom_range(0, 2) == 0);
        rd1 = $urandom_range(0, 1); wr1 = ($urandom_range(0, 2) == 0);
        addr0 = rand_addr(); addr1 = rand_addr();
        wdata0 = $urandom; wdata1 = $urandom;
        irq = ($urandom_range(0, 3) == 0);
        sw = $urandom;
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt",    {30'd0, gnt1, gnt0}, {30'd0, e.gnt});
            check("strobe", {30'd0, wr, rd},     {30'd0, e.strb});
            check("addr",   addr,   e.addr);
            check("wdata",  wdata,  e.wdata);
            check("rdata0", rdata0, e.rdata0);
            check("rdata1", rdata1, e.rdata1);
        end
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            pregs[i] = 32'(i);
            mregs[i] = 32'(i);
        end
        // Reset held: everything must read zero
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req0 = 1; req1 = 1; step();
        end
        @(negedge clk); reset = 1'b1; req0 = 0; req1 = 0; step();

        // Broad random traffic, light then heavy locking
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); rand_inputs(60, 20); step();
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); rand_inputs(85, 70); step();
        end

        // Locked contention: master 0 keeps the bus for MAX_HOLD transfers
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); rand_inputs(100, 0);
            irq = 0; req0 = 1; req1 = 1; lock0 = 1; lock1 = 0; step();
        end
        // Unlocked contention: strict alternation
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); rand_inputs(100, 0);
            irq = 0; req0 = 1; req1 = 1; step();
        end

        // Single master write of 0xA5 to the LED register
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rand_inputs(0, 0);
            irq = 0; req1 = (i < 3); wr1 = 1; rd1 = 0;
            addr1 = 32'h4000000C; wdata1 = 32'h000000A5; step();
        end
        @(negedge clk); rand_inputs(0, 0); irq = 0; step();
        check("led_reg", pregs[3], 32'h000000A5);

        // Read routing from the switch register
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rand_inputs(0, 0);
            irq = 0; req0 = 1; rd0 = 1; wr0 = 0; addr0 = 32'h40000010; sw = 32'h0000003C; step();
        end

        // Asynchronous reset in the middle of a master-1 read
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rand_inputs(0, 0);
            irq = 0; req1 = 1; rd1 = 1; wr1 = 0; addr1 = 32'h40000004; step();
        end
        #3 reset = 1'b0;
        #1;
        check("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_strb",  {30'd0, wr, rd},     32'd0);
        check("rst_addr",  addr,   32'd0);
        check("rst_rdata", rdata0 | rdata1, 32'd0);
        owner = -1; last = 1; held = 0;
        @(negedge clk); req0 = 1; req1 = 1; step();
        @(negedge clk); reset = 1'b1; step();
        @(negedge clk); step();

        // Master 1 locked; master 0 arrives with the timer interrupt
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rand_inputs(0, 0);
            irq = 0; req1 = 1; lock1 = 1; step();
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); rand_inputs(100, 0);
            irq = (i < 10); req0 = 1; req1 = 1; lock1 = 1; lock0 = 0; step();
        end

        for (int i = 0; i < 100; i++) begin
            @(negedge clk); rand_inputs(70, 40); step();
        end
        @(negedge clk); rand_inputs(0, 0); step();
        repeat (3) @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
